// File: rtl/pulse_merger.sv
// rtl/pulse_merger.sv - merges a sparse pulse stream into contiguous bursts
module pulse_merger #(
  parameter int PULSE_COUNTER_WIDTH = 3,
  parameter int GAP_CYCLES          = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic pulse_in,
  output logic pulse_out,
  output logic busy
);

  localparam int W  = PULSE_COUNTER_WIDTH;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [W-1:0]  COUNT_MAX = {W{1'b1}};
  localparam logic [W-1:0]  COUNT_ONE = W'(1);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    count_q, count_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            pulse_out_q;
  logic            busy_q;

  // Next-state decode; outputs are derived from the next state so they come straight off flops
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (pulse_in) begin
          state_d = COLLECT;
          count_d = COUNT_ONE;
          gap_d   = '0;
        end
      end
      COLLECT: begin
        if (pulse_in) begin
          // A saturated counter drops the pulse but still restarts the gap window
          gap_d = '0;
          if (count_q != COUNT_MAX) begin
            count_d = count_q + COUNT_ONE;
          end
        end else if (gap_q == GAP_LAST) begin
          state_d = EMIT;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      EMIT: begin
        // An incoming pulse cancels the one being emitted, so the burst simply stretches
        if (!pulse_in) begin
          if (count_q == COUNT_ONE) begin
            state_d = IDLE;
            count_d = '0;
          end else begin
            count_d = count_q - COUNT_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        gap_d   = '0;
      end
    endcase
  end

  // State, counters and registered outputs with asynchronous clear
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      count_q     <= '0;
      gap_q       <= '0;
      pulse_out_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      pulse_out_q <= (state_d == EMIT);
      busy_q      <= (state_d == COLLECT) && (count_d == COUNT_MAX);
    end
  end

  assign pulse_out = pulse_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pulse_merger.sv
// tb/tb_pulse_merger.sv - directed self-checking bench for pulse_merger
module tb_pulse_merger;

  logic clock = 1'b0;
  logic resetn;
  logic pulse_in;
  logic pulse_out;
  logic busy;
  logic pulse_in_g1;
  logic pulse_out_g1;
  logic busy_g1;

  int errors = 0;
  int checks = 0;

  pulse_merger #(.PULSE_COUNTER_WIDTH(3), .GAP_CYCLES(2)) u_dut (
    .clock     (clock),
    .resetn    (resetn),
    .pulse_in  (pulse_in),
    .pulse_out (pulse_out),
    .busy      (busy)
  );

  pulse_merger #(.PULSE_COUNTER_WIDTH(1), .GAP_CYCLES(1)) u_dut_g1 (
    .clock     (clock),
    .resetn    (resetn),
    .pulse_in  (pulse_in_g1),
    .pulse_out (pulse_out_g1),
    .busy      (busy_g1)
  );

  always #5 clock = ~clock;

  // Drive inputs, then advance one rising edge and settle just after it
  task automatic cycle(input logic p, input logic p_g1);
    pulse_in    = p;
    pulse_in_g1 = p_g1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn      = 1'b0;
    pulse_in    = 1'b0;
    pulse_in_g1 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (pulse_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulse_out got %b exp 0", pulse_out);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b exp 0", busy);
    end
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (pulse_out !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d got out=%b busy=%b exp out=0 busy=0", i, pulse_out, busy);
      end
    end
  endtask

  task automatic test_single_pulse();
    bit in_v [5];
    bit out_v [5];
    in_v  = '{1, 0, 0, 0, 0};
    out_v = '{0, 0, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      cycle(in_v[i], 1'b0);
      checks++;
      if (pulse_out !== out_v[i]) begin
        errors++;
        $display("FAIL single_out cyc%0d got %b exp %b", i, pulse_out, out_v[i]);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL single_busy cyc%0d got %b exp 0", i, busy);
      end
    end
  endtask

  task automatic test_spaced_pulses();
    bit in_v [14];
    bit out_v [14];
    in_v  = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    out_v = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 14; i++) begin
      cycle(in_v[i], 1'b0);
      checks++;
      if (pulse_out !== out_v[i]) begin
        errors++;
        $display("FAIL spaced_out cyc%0d got %b exp %b", i, pulse_out, out_v[i]);
      end
    end
  endtask

  task automatic test_two_groups();
    bit in_v [16];
    bit out_v [16];
    in_v  = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    out_v = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    for (int i = 0; i < 16; i++) begin
      cycle(in_v[i], 1'b0);
      checks++;
      if (pulse_out !== out_v[i]) begin
        errors++;
        $display("FAIL groups_out cyc%0d got %b exp %b", i, pulse_out, out_v[i]);
      end
    end
  endtask

  task automatic test_saturation();
    bit in_v [20];
    bit out_v [20];
    bit busy_v [20];
    in_v   = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    out_v  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    busy_v = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 20; i++) begin
      cycle(in_v[i], 1'b0);
      checks++;
      if (pulse_out !== out_v[i]) begin
        errors++;
        $display("FAIL sat_out cyc%0d got %b exp %b", i, pulse_out, out_v[i]);
      end
      checks++;
      if (busy !== busy_v[i]) begin
        errors++;
        $display("FAIL sat_busy cyc%0d got %b exp %b", i, busy, busy_v[i]);
      end
    end
  endtask

  task automatic test_emit_extension();
    bit in_v [12];
    bit out_v [12];
    in_v  = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    out_v = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      cycle(in_v[i], 1'b0);
      checks++;
      if (pulse_out !== out_v[i]) begin
        errors++;
        $display("FAIL extend_out cyc%0d got %b exp %b", i, pulse_out, out_v[i]);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL extend_busy cyc%0d got %b exp 0", i, busy);
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    bit in_v [7];
    bit out_v [7];
    bit post_in [5];
    bit post_out [5];
    in_v     = '{1, 1, 1, 1, 0, 0, 0};
    out_v    = '{0, 0, 0, 0, 0, 1, 1};
    post_in  = '{1, 0, 0, 0, 0};
    post_out = '{0, 0, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      cycle(in_v[i], 1'b0);
      checks++;
      if (pulse_out !== out_v[i]) begin
        errors++;
        $display("FAIL rst_emit_pre cyc%0d got %b exp %b", i, pulse_out, out_v[i]);
      end
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (pulse_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_emit_async got out=%b busy=%b exp out=0 busy=0", pulse_out, busy);
    end
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    checks++;
    if (pulse_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_emit_held got %b exp 0", pulse_out);
    end
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (pulse_out !== 1'b0) begin
        errors++;
        $display("FAIL rst_emit_quiet cyc%0d got %b exp 0", i, pulse_out);
      end
    end
    for (int i = 0; i < 5; i++) begin
      cycle(post_in[i], 1'b0);
      checks++;
      if (pulse_out !== post_out[i]) begin
        errors++;
        $display("FAIL rst_emit_fresh cyc%0d got %b exp %b", i, pulse_out, post_out[i]);
      end
    end
  endtask

  task automatic test_reset_busy();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy_pre got %b exp 1", busy);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || pulse_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_async got busy=%b out=%b exp busy=0 out=0", busy, pulse_out);
    end
    cycle(1'b0, 1'b0);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0);
      checks++;
      if (pulse_out !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_busy_after cyc%0d got out=%b busy=%b exp out=0 busy=0", i, pulse_out, busy);
      end
    end
  endtask

  task automatic test_gap_one();
    bit in_v [8];
    bit out_v [8];
    bit busy_v [8];
    in_v   = '{1, 1, 1, 0, 0, 1, 0, 0};
    out_v  = '{0, 0, 0, 1, 0, 0, 1, 0};
    busy_v = '{1, 1, 1, 0, 0, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, in_v[i]);
      checks++;
      if (pulse_out_g1 !== out_v[i]) begin
        errors++;
        $display("FAIL gap1_out cyc%0d got %b exp %b", i, pulse_out_g1, out_v[i]);
      end
      checks++;
      if (busy_g1 !== busy_v[i]) begin
        errors++;
        $display("FAIL gap1_busy cyc%0d got %b exp %b", i, busy_g1, busy_v[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_spaced_pulses();
    test_two_groups();
    test_saturation();
    test_emit_extension();
    test_reset_mid_emit();
    test_reset_busy();
    test_gap_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
